// File: rtl/pk_poci.sv
// Shared POCI types and constants for the peripheral bus arbiter.
// Holds the arbiter state enum, the request/response bundles and the region tag.
package pk_poci;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    DECERR
  } poci_arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } poci_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } poci_rsp_t;

  localparam logic [3:0] region_hi = 4'h8;

endpackage

// File: rtl/poci_rr_arb2.sv
// Two-way round-robin grant logic; pointer advances past the winner on update.
// Ports: clk, reset (sync, active-high), req[1:0], update -> one-hot gnt[1:0].
module poci_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // ptr_q = 1 means m1 wins a tie
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    if (update && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/poci_arbiter.sv
// Shares the POCI bus between m0 (core) and m1 (debug); sequences setup/access.
// Ports: mN_* requester side, p* POCI side. Macro POCI_ARB_TIMEOUT_EN adds an access timeout.
module poci_arbiter
  import pk_poci::*;
#(
  parameter logic [3:0]  REGION_HI = region_hi,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_write,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_write,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] paddr,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  poci_arb_state_t state_q, state_d;
  poci_req_t       req_q, req_d, req_in;
  poci_rsp_t       rsp_q, rsp_d;
  logic            owner_q, owner_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [1:0]      rvalid_q, rvalid_d;
  logic [1:0]      err_q, err_d;
  logic [1:0]      arb_req, arb_gnt;
  logic            take;

`ifdef POCI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  // Requests are only considered in IDLE, never while reset is held
  assign arb_req = (state_q == IDLE && !reset) ? {m1_req, m0_req} : 2'b00;
  assign take    = |arb_gnt;
  assign m0_gnt  = arb_gnt[0];
  assign m1_gnt  = arb_gnt[1];

  poci_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .update (take),
    .gnt    (arb_gnt)
  );

  assign req_in = arb_gnt[1] ? '{m1_addr, m1_write, m1_wdata}
                             : '{m0_addr, m0_write, m0_wdata};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    owner_d = owner_q;
`ifdef POCI_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (take) begin
          req_d   = req_in;
          owner_d = arb_gnt[1];
          if (req_in.addr[31:28] == REGION_HI) begin
            state_d = SETUP;
          end else begin
            state_d = DECERR;
            rsp_d   = '{32'h0, 1'b1};
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef POCI_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          rsp_d   = '{prdata, pslverr};
          state_d = RESP;
        end
`ifdef POCI_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rsp_d   = '{32'h0, 1'b1};
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      DECERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    rvalid_d  = 2'b00;
    err_d     = 2'b00;
    if (state_d == RESP || state_d == DECERR) begin
      rvalid_d = owner_d ? 2'b10 : 2'b01;
      err_d    = rsp_d.err ? rvalid_d : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rsp_q     <= '0;
      owner_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 2'b00;
      err_q     <= 2'b00;
`ifdef POCI_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rsp_q     <= rsp_d;
      owner_q   <= owner_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
`ifdef POCI_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign paddr     = req_q.addr;
  assign pwrite    = req_q.write;
  assign pwdata    = req_q.wdata;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rsp_q.rdata;
  assign m1_rdata  = rsp_q.rdata;

endmodule

// File: doc/poci_arbiter.md
Name: poci_arbiter

Overview:
- Shares the single POCI peripheral bus (LEDs, HEX, keys, switches at 0x8000_0000 and up) between two requesters: m0 is the core data port, m1 is the debug/loader port.
- Arbitrates round-robin and sequences the two-phase POCI transfer (setup, then access).
- Returns a one-cycle response pulse to the granted requester.
- Rejects out-of-region addresses locally with an error and never drives the bus for them.

Parameters:
- REGION_HI, 4'h8, required value of addr[31:28] for a transfer to be forwarded to the bus.
- TIMEOUT, 16, access-phase cycle limit; used only with POCI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mN_req  in  1  request for N = 0, 1; held until mN_gnt
- mN_addr  in  32  byte address
- mN_write  in  1  1 = write, 0 = read
- mN_wdata  in  32  write data
- mN_gnt  out  1  request accepted; one-cycle pulse
- mN_rvalid  out  1  response valid; one-cycle pulse
- mN_rdata  out  32  read data; valid with mN_rvalid
- mN_err  out  1  error; valid with mN_rvalid
- paddr  out  32  POCI address
- pwrite  out  1  POCI direction
- psel  out  1  POCI select
- penable  out  1  POCI access phase
- pwdata  out  32  POCI write data
- prdata  in  32  POCI read data
- pready  in  1  POCI ready
- pslverr  in  1  POCI slave error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0, state IDLE, rr pointer favours m0.
- State machine: IDLE, SETUP, ACCESS, RESP, DECERR.
- IDLE:
  - If any request is pending, pick the winner: with a single requester it wins; with both, the one not granted last wins.
  - mN_gnt is asserted combinationally in this same cycle.
  - Latch addr, write and wdata, and record the owner.
  - Next state is SETUP if addr[31:28] == REGION_HI, else DECERR.
- SETUP: psel=1, penable=0; paddr, pwrite and pwdata come from the latch. Next state is ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - Stay in ACCESS while pready=0.
  - On pready=1, capture prdata and pslverr, then go to RESP.
- RESP: owner sees rvalid=1 with the captured data and err. psel=0. Next state is IDLE.
- DECERR: owner sees rvalid=1, err=1, rdata=0. No bus activity. Next state is IDLE.
- Latency:
  - Request in IDLE at T gives gnt at T, SETUP at T+1, ACCESS from T+2.
  - rvalid arrives the cycle after pready is sampled high, so zero-wait rvalid is at T+3.
  - A DECERR response arrives at T+1.
- Throughput: at most one transfer is in flight. The next grant can occur in the IDLE cycle after RESP, giving 4 cycles per zero-wait transfer.
- Both requesters active continuously: grants alternate strictly m0, m1, m0, …
- A request arriving in any state other than IDLE waits. No request is dropped; requesters hold req until gnt.
- rdata is undefined for writes, but is driven from the captured prdata.
- Reset asserted mid-transfer: the next cycle is IDLE with psel=penable=0. The transfer is abandoned and no rvalid is issued; peripherals are in the same reset domain.
- mN_rvalid, mN_gnt and mN_err are never asserted for the non-owner.

Optional Feature:
- Macro: POCI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT-1 with pready still 0, the next state is RESP with err=1 and rdata=0; psel and penable deassert.
- Undefined: no counter exists, and ACCESS waits indefinitely.

Decomposition:
- Additions to pk_poci:
  - poci_arb_state_t enum (IDLE, SETUP, ACCESS, RESP, DECERR)
  - poci_req_t struct (addr, write, wdata)
  - poci_rsp_t struct (rdata, err)
  - constant region_hi = 4'h8
- Sub-module poci_rr_arb2: 2-way round-robin grant logic.
  - Inputs: req[1:0] and update strobe.
  - Output: one-hot gnt[1:0].
  - Holds its pointer internally.

Test Plan:
- m0 read from 0x8000_1010, pready=1 immediately, prdata=0x0000_00A5 -> gnt0@T, psel@T+1, penable@T+2, rvalid0@T+3, rdata0=0xA5, err0=0.
- m1 write 0x8000_0010 data 0x55, pready low for 3 ACCESS cycles -> penable held 4 cycles, pwdata=0x55 stable, rvalid1 one cycle after pready.
- m0 and m1 request together continuously for 6 transfers -> grants in order m0, m1, m0, m1, m0, m1, with no overlapping psel.
- m0 read from 0x1000_0000 -> no psel at any point, rvalid0@T+1, err0=1, rdata0=0.
- reset asserted in ACCESS -> psel=penable=0 next cycle, no rvalid; a subsequent m1 request is granted at its arrival cycle.
- POCI_ARB_TIMEOUT_EN defined, TIMEOUT=16, pready held 0 -> after 16 ACCESS cycles, RESP with err=1, rdata=0, psel drops.
